// File: rtl/coreapb_initiator_pkg.sv
// rtl/coreapb_initiator_pkg.sv - shared types and defaults for the APB initiator
package coreapb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_DWIDTH  = 32;
  localparam int DEF_AWIDTH  = 17;
  localparam int DEF_TIMEOUT = 16;
  // Wide enough for the largest supported TIMEOUT (255)
  localparam int WDOG_CW     = 8;

endpackage

// File: rtl/coreapb_init_wdog.sv
// rtl/coreapb_init_wdog.sv - saturating wait-state counter flagging the LIMIT-th consecutive wait
module coreapb_init_wdog
  import coreapb_initiator_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WDOG_CW-1:0] CNT_MAX = '1;
  localparam logic [WDOG_CW-1:0] CNT_LAST = WDOG_CW'(LIMIT - 1);

  logic [WDOG_CW-1:0] count_q;
  logic [WDOG_CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != CNT_MAX)) begin
      count_d = count_q + WDOG_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the waits already seen, so this wait is number count_q+1
  assign expired = count_en && (count_q >= CNT_LAST);

endmodule

// File: rtl/coreapb_initiator.sv
// rtl/coreapb_initiator.sv - single-outstanding command/response to APB master bridge
module coreapb_initiator
  import coreapb_initiator_pkg::*;
#(
  parameter int APB_DWIDTH = DEF_DWIDTH,
  parameter int APB_AWIDTH = DEF_AWIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_AWIDTH-1:0] cmd_addr,
  input  logic [APB_DWIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DWIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_AWIDTH-1:0] PADDR,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e             state_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [APB_AWIDTH-1:0]  paddr_q;
  logic [APB_DWIDTH-1:0]  pwdata_q;
  logic                   rsp_valid_q;
  logic [APB_DWIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   rsp_timeout_q;

  logic accept_w;
  logic wait_en_w;
  logic expired_w;

  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
  assign accept_w  = cmd_valid && cmd_ready;
  assign wait_en_w = (state_q == ACCESS) && !PREADY;

  coreapb_init_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk      (PCLK),
    .rst_n    (PRESETN),
    .clear    (accept_w),
    .count_en (wait_en_w),
    .expired  (expired_w)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // A response can never be pending here, so overwriting rsp_* is safe
          if (PREADY) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
          end else if (expired_w) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_coreapb_initiator.sv
// tb/tb_coreapb_initiator.sv - directed self-checking bench for coreapb_initiator
module tb_coreapb_initiator;

  logic        PCLK;
  logic        PRESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [16:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [16:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  // Completer model: small SRAM, programmable wait states, stuck-low option
  logic [31:0] mem [0:15];
  int          acc_cnt;
  int          wait_states;
  logic        stuck_low;
  logic        slverr;

  coreapb_initiator #(
    .APB_DWIDTH (32),
    .APB_AWIDTH (17),
    .TIMEOUT    (16)
  ) dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PRDATA  = mem[PADDR[5:2]];
  assign PREADY  = stuck_low ? 1'b0 : (acc_cnt >= wait_states);
  assign PSLVERR = slverr;

  always @(posedge PCLK) begin
    acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    if (PSEL && PENABLE && PREADY && PWRITE)
      mem[PADDR[5:2]] <= PWDATA;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Issues one command and follows it until rsp_valid (bounded)
  task automatic do_cmd(input logic w, input logic [16:0] a, input logic [31:0] d,
                        output int lat, output int n_setup, output int n_access,
                        output bit stable);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    lat = 0; n_setup = 0; n_access = 0; stable = 1'b1;
    do begin
      tick();
      lat++;
      cmd_valid = 1'b0;
      if (PSEL && !PENABLE) n_setup++;
      if (PSEL && PENABLE) n_access++;
      if (PSEL && ((PADDR !== a) || (PWRITE !== w) || (w && (PWDATA !== d)))) stable = 1'b0;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, ns, na;
    bit st;

    PRESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; wait_states = 0; stuck_low = 1'b0; slverr = 1'b0;
    tick(); tick();
    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rst_paddr", {15'd0, PADDR}, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    PRESETN = 1'b1;

    // Zero-wait write
    do_cmd(1'b1, 17'h10, 32'hDEADBEEF, lat, ns, na, st);
    check("wr_latency", lat, 3);
    check("wr_setup_cycles", ns, 1);
    check("wr_access_cycles", na, 1);
    check("wr_stable", {31'd0, st}, 32'd1);
    check("wr_psel_done", {31'd0, PSEL}, 32'd0);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    handshake();
    check("wr_rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    check("wr_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait read back
    do_cmd(1'b0, 17'h10, 32'h0, lat, ns, na, st);
    check("rd_latency", lat, 3);
    check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_stable", {31'd0, st}, 32'd1);
    check("rd_err", {31'd0, rsp_err}, 32'd0);
    handshake();

    // Read with 5 wait states
    wait_states = 5;
    do_cmd(1'b0, 17'h10, 32'h0, lat, ns, na, st);
    check("ws_access_cycles", na, 6);
    check("ws_latency", lat, 8);
    check("ws_stable", {31'd0, st}, 32'd1);
    check("ws_rdata", rsp_rdata, 32'hDEADBEEF);
    check("ws_timeout", {31'd0, rsp_timeout}, 32'd0);
    handshake();
    wait_states = 0;

    // PREADY stuck low: abort on the 16th wait
    stuck_low = 1'b1;
    do_cmd(1'b0, 17'h10, 32'h0, lat, ns, na, st);
    check("to_access_cycles", na, 16);
    check("to_latency", lat, 18);
    check("to_err", {31'd0, rsp_err}, 32'd1);
    check("to_timeout", {31'd0, rsp_timeout}, 32'd1);
    check("to_rdata", rsp_rdata, 32'd0);
    check("to_psel", {31'd0, PSEL}, 32'd0);
    handshake();
    stuck_low = 1'b0;

    // Slave error on write, response held back for 4 cycles
    slverr = 1'b1;
    do_cmd(1'b1, 17'h08, 32'h12345678, lat, ns, na, st);
    slverr = 1'b0;
    check("se_latency", lat, 3);
    check("se_err", {31'd0, rsp_err}, 32'd1);
    check("se_timeout", {31'd0, rsp_timeout}, 32'd0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 17'h0C;
    for (int i = 0; i < 4; i++) begin
      check("se_cmd_ready_held", {31'd0, cmd_ready}, 32'd0);
      check("se_rsp_held", {31'd0, rsp_valid}, 32'd1);
      tick();
      check("se_no_new_psel", {31'd0, PSEL}, 32'd0);
    end
    cmd_valid = 1'b0;
    handshake();
    check("se_no_accept_on_hs", {31'd0, PSEL}, 32'd0);
    check("se_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Reset during ACCESS abandons the transfer
    stuck_low = 1'b1;
    cmd_write = 1'b0; cmd_addr = 17'h10; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("mr_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
    PRESETN = 1'b0;
    #1;
    check("mr_psel", {31'd0, PSEL}, 32'd0);
    check("mr_penable", {31'd0, PENABLE}, 32'd0);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    PRESETN = 1'b1;
    stuck_low = 1'b0;
    check("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_cmd(1'b1, 17'h04, 32'h1, lat, ns, na, st);
    check("mr_wr_latency", lat, 3);
    check("mr_wr_err", {31'd0, rsp_err}, 32'd0);
    handshake();
    do_cmd(1'b0, 17'h04, 32'h0, lat, ns, na, st);
    check("mr_rd_rdata", rsp_rdata, 32'h1);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
